// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one off-chip memory port between the I-cache and
// D-cache controllers, one transaction at a time, with a sticky watchdog flag.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int TIMEOUT = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic              i_write_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic [LINE_W-1:0] i_data_i,
  output logic              i_ack_o,
  output logic [LINE_W-1:0] i_data_o,
  input  logic              d_req_i,
  input  logic              d_write_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [LINE_W-1:0] d_data_i,
  output logic              d_ack_o,
  output logic [LINE_W-1:0] d_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic              timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e              state_q;
  logic                grant_q;
  logic                lastGrant_q;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   data_q;
  logic [CNT_W-1:0]    wdCount_q;
  logic                timeout_q;

  logic                busy;
  logic                anyReq;
  logic                pickD_d;
  logic                wdFire;

  always_comb begin
    busy    = (state_q == BUSY);
    anyReq  = i_req_i | d_req_i;
    // On a tie the port that was not granted last wins; pointer 0 means I.
    pickD_d = d_req_i & (~i_req_i | ~lastGrant_q);
    wdFire  = busy & ~mem_ack_i & (wdCount_q == CNT_W'(TIMEOUT - 1));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      wdCount_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            state_q     <= BUSY;
            grant_q     <= pickD_d;
            lastGrant_q <= pickD_d;
            write_q     <= pickD_d ? d_write_i : i_write_i;
            addr_q      <= pickD_d ? d_addr_i  : i_addr_i;
            data_q      <= pickD_d ? d_data_i  : i_data_i;
            wdCount_q   <= '0;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
          end else if (wdCount_q != CNT_W'(TIMEOUT)) begin
            wdCount_q <= wdCount_q + CNT_W'(1);
          end
        end
      endcase
      if (wdFire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // The watchdog flag shows in the very BUSY cycle that reaches the limit.
  assign timeout_o    = timeout_q | wdFire;
  assign mem_enable_o = busy;
  assign mem_write_o  = write_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;
  assign i_ack_o      = busy & mem_ack_i & ~grant_q;
  assign d_ack_o      = busy & mem_ack_i & grant_q;
  assign i_data_o     = mem_data_i;
  assign d_data_o     = mem_data_i;

endmodule
